// File: rtl/adder_verif_pkg.sv
// Shared definitions for the adder sweep checker: FSM state encodings,
// stimulus mode encodings and the 33-bit stimulus LFSR polynomial.
package adder_verif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    typedef enum logic {
        MODE_SWEEP = 1'b0,
        MODE_LFSR  = 1'b1
    } mode_e;

    // x^33 + x^20 + 1, Fibonacci form: taps on bit 32 and bit 19.
    // Matches the stimulus vector width 2*16+1.
    localparam logic [32:0] LFSR33_TAPS = 33'h1_0008_0000;

endpackage

// File: rtl/vec_lfsr.sv
// Fibonacci LFSR producing the pseudo-random stimulus vector.
// Shifts towards the MSB; the parity of the tapped bits enters at bit 0.
module vec_lfsr
    import adder_verif_pkg::*;
#(
    parameter int             VW   = 33,
    parameter logic [VW-1:0]  TAPS = VW'(LFSR33_TAPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [VW-1:0] seed,
    input  logic          step,
    output logic [VW-1:0] q
);

    logic [VW-1:0] q_q;
    logic          fb;

    assign fb = ^(q_q & TAPS);
    assign q  = q_q;

    // Load has priority over step so a start can re-seed at any time.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else if (load) begin
            q_q <= seed;
        end else if (step) begin
            q_q <= {q_q[VW-2:0], fb};
        end
    end

endmodule

// File: rtl/adder_sweep_checker.sv
// Start/done controlled stimulus generator and result comparator for a
// WIDTH-bit adder and its golden reference. Vectors are {c_in,a,b}.
module adder_sweep_checker
    import adder_verif_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int DUT_LAT = 0,
    parameter  int ERR_W   = 16,
    localparam int VW      = 2*WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [VW-1:0]    seed,
    input  logic [VW-1:0]    num_vectors,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             c_in,
    input  logic [WIDTH-1:0] sum_dut,
    input  logic             cout_dut,
    input  logic [WIDTH-1:0] sum_ref,
    input  logic             cout_ref,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_vld,
    output logic [VW-1:0]    first_err_vec
);

    state_e          state_q;
    mode_e           mode_q;
    logic            busy_q;
    logic            done_q;
    logic [VW-1:0]   num_q;
    logic [VW-1:0]   cnt_q;
    logic [VW-1:0]   sweep_q;
    logic [ERR_W-1:0] err_q;
    logic            ferr_vld_q;
    logic [VW-1:0]   ferr_vec_q;

    logic [VW-1:0]   lfsr_q;
    logic [VW-1:0]   stim;
    logic            start_ok;
    logic            last_issue;
    logic            lfsr_load;
    logic            lfsr_step;
    logic            mismatch;
    logic            tag_src;
    logic [VW-1:0]   vec_src;
    logic            cmp_tag;
    logic [VW-1:0]   cmp_vec;

    assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_issue = (state_q == ST_RUN) && (cnt_q == num_q - VW'(1));
    // A zero LFSR seed would lock up the generator, so it is replaced by 1.
    assign lfsr_load  = start_ok && (mode == MODE_LFSR);
    // The final issue edge does not advance, so a/b/c_in hold the last vector.
    assign lfsr_step  = (state_q == ST_RUN) && (mode_q == MODE_LFSR) && !last_issue;

    vec_lfsr #(
        .VW   (VW),
        .TAPS (VW'(LFSR33_TAPS))
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed ((seed == '0) ? VW'(1) : seed),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    assign stim            = (mode_q == MODE_LFSR) ? lfsr_q : sweep_q;
    assign {c_in, a, b}    = stim;
    assign busy            = busy_q;
    assign done            = done_q;
    assign err_count       = err_q;
    assign first_err_vld   = ferr_vld_q;
    assign first_err_vec   = ferr_vec_q;

    // A vector is live on a/b/c_in for exactly the cycles spent in RUN.
    assign tag_src  = (state_q == ST_RUN);
    assign vec_src  = stim;
    assign mismatch = (sum_dut != sum_ref) || (cout_dut != cout_ref);

    genvar gi;
    generate
        for (gi = 0; gi < DUT_LAT; gi++) begin : g_stage
            logic          tag_in;
            logic          tag_q;
            logic [VW-1:0] vec_in;
            logic [VW-1:0] vec_q;
            if (gi == 0) begin : g_head
                assign tag_in = tag_src;
                assign vec_in = vec_src;
            end else begin : g_link
                assign tag_in = g_stage[gi-1].tag_q;
                assign vec_in = g_stage[gi-1].vec_q;
            end
            // One delay stage aligning the issued vector with the adder result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_q <= 1'b0;
                    vec_q <= '0;
                end else begin
                    tag_q <= tag_in;
                    vec_q <= vec_in;
                end
            end
        end
        if (DUT_LAT == 0) begin : g_nolat
            assign cmp_tag = tag_src;
            assign cmp_vec = vec_src;
        end else begin : g_lat
            assign cmp_tag = g_stage[DUT_LAT-1].tag_q;
            assign cmp_vec = g_stage[DUT_LAT-1].vec_q;
        end
    endgenerate

    // Control FSM plus compare bookkeeping; a start clears results after any compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_SWEEP;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            num_q      <= '0;
            cnt_q      <= '0;
            sweep_q    <= '0;
            err_q      <= '0;
            ferr_vld_q <= 1'b0;
            ferr_vec_q <= '0;
        end else begin
            if (cmp_tag && mismatch) begin
                if (err_q != '1) begin
                    err_q <= err_q + ERR_W'(1'b1);
                end
                if (!ferr_vld_q) begin
                    ferr_vld_q <= 1'b1;
                    ferr_vec_q <= cmp_vec;
                end
            end
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        mode_q     <= mode_e'(mode);
                        num_q      <= num_vectors;
                        cnt_q      <= '0;
                        sweep_q    <= seed;
                        err_q      <= '0;
                        ferr_vld_q <= 1'b0;
                        ferr_vec_q <= '0;
                        if (num_vectors == '0) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (last_issue) begin
                        cnt_q <= '0;
                        if (DUT_LAT == 0) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end else begin
                        cnt_q <= cnt_q + VW'(1);
                        if (mode_q == MODE_SWEEP) begin
                            sweep_q <= sweep_q + VW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // DRAIN lasts DUT_LAT cycles; the last one compares vector N-1.
                    if (cnt_q == VW'(DUT_LAT - 1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + VW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
